multi_operand_adder_pipe: RTL
=============================

Name: multi_operand_adder_pipe

Overview:
- Parametrised, pipelined successor to the 8-operand, 7-bit linear-chain adder.
- Sums NUM_OPS unsigned operands of WIDTH bits plus a carry-in.
- Uses a registered binary reduction tree with a valid/ready handshake on both sides.
- Returns both a full-precision sum and a WIDTH-bit wrapped sum with an overflow flag. Sits between operand-gathering logic and the downstream accumulator/compare path.

Parameters:
- WIDTH, 7, bits per operand (≥1)
- NUM_OPS, 8, number of operands (≥2, need not be a power of two)
- Derived, not overridable: LEVELS = $clog2(NUM_OPS); SUM_W = WIDTH + $clog2(NUM_OPS)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- ops  in  NUM_OPS*WIDTH  operand i at ops[i*WIDTH +: WIDTH]
- ci  in  1  carry-in, added once
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum_full  out  SUM_W  exact sum of all operands + ci
- s  out  WIDTH  sum_full[WIDTH-1:0]
- ovf  out  1  1 when sum_full[SUM_W-1:WIDTH] != 0

Behaviour:
- Reset: all stage valid bits, out_valid, sum_full, s and ovf are 0. in_ready = 1 once rst deasserts.
- Advance: adv = !out_valid || out_ready. Every pipeline register loads only when adv = 1. in_ready = adv (combinational from out_valid/out_ready, never from in_valid).
- Accept: a beat is taken when in_valid && in_ready.
- Level 1 pairs operands (0,1), (2,3), …. Operand pair 0 also adds ci. An odd last operand is zero-extended and passes through the level unchanged.
- Levels 2..LEVELS repeat the pairing on the previous level's registered partial sums.
- Each level widens its results by 1 bit, capped at SUM_W. No intermediate truncation, so sum_full is exact.
- Latency is exactly LEVELS cycles from acceptance to out_valid, with no stalls. Default config: 3 cycles.
- Throughput is one beat per cycle while out_ready = 1.
- Each stage carries its own valid bit. Bubbles are not collapsed; the whole pipe shifts only when adv = 1.
- Stall: with out_valid = 1 and out_ready = 0, every stage holds, in_ready = 0, and outputs stay stable.
- Simultaneous output pop and input push in the same cycle are both honoured; no beat is lost or duplicated.
- flush: when asserted, all stage valids clear on that edge; a beat presented in the same cycle is dropped; flush has priority over adv. Data registers need not clear.
- rst mid-operation: all in-flight beats are discarded immediately and out_valid drops asynchronously.
- ovf and s derive from the registered sum_full and are valid whenever out_valid = 1.

Decomposition:
- Package adder_pkg: function for level count; function for per-level width (min(WIDTH+level, SUM_W)); localparam SUM_W.
- One sub-module, adder_tree_level: a parametrised single reduction level.
  - Parameters: IN_CNT, IN_W, OUT_W, HAS_CI.
  - Combinational pairwise add, registered output, enable input, valid pass-through.
  - Top instantiates LEVELS copies in a generate loop.

Test Plan:
- WIDTH=7, NUM_OPS=8; all ops=127, ci=1, out_ready=1 -> after 3 cycles sum_full=1017, s=121, ovf=1.
- All ops=0, ci=0 -> sum_full=0, s=0, ovf=0. Then ops=i+1 (1..8), ci=0 -> sum_full=36, s=36, ovf=0.
- 10 back-to-back beats with out_ready held 0 after beat 2 for 5 cycles, then released -> in_ready=0 during stall, outputs stable, all 10 results in order, none dropped.
- NUM_OPS=5, WIDTH=4; ops all 15, ci=1 -> LEVELS=3, SUM_W=7, sum_full=76, s=12, ovf=1.
- flush asserted while 2 beats in flight -> no out_valid for those beats; next beat (ops=1, ci=0 → 8) emerges 3 cycles after acceptance.
- rst pulsed asynchronously mid-stream -> out_valid=0 immediately; after release, in_ready=1 and the next beat produces a correct result.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared sizing helpers for the multi-operand reduction-tree adder.
// Tree shape (levels, per-level operand counts and widths) is derived from WIDTH/NUM_OPS.
package adder_pkg;

  localparam int unsigned WIDTH_DEF   = 7;
  localparam int unsigned NUM_OPS_DEF = 8;
  localparam int unsigned SUM_W       = WIDTH_DEF + $clog2(NUM_OPS_DEF);

  // Number of pairwise reduction levels needed to reach a single sum.
  function automatic int unsigned level_count(input int unsigned num_ops);
    return $clog2(num_ops);
  endfunction

  // Width of the exact total: operand width plus one bit per level.
  function automatic int unsigned sum_width(input int unsigned width, input int unsigned num_ops);
    return width + $clog2(num_ops);
  endfunction

  // Partial-sum width after `level` levels, capped at the full sum width.
  function automatic int unsigned level_width(input int unsigned width, input int unsigned num_ops,
                                              input int unsigned level);
    int unsigned w;
    w = width + level;
    if (w > sum_width(width, num_ops)) w = sum_width(width, num_ops);
    return w;
  endfunction

  // Count of partial sums present after `level` levels (odd leftovers pass through).
  function automatic int unsigned level_ops(input int unsigned num_ops, input int unsigned level);
    int unsigned cnt;
    cnt = num_ops;
    for (int unsigned i = 0; i < level; i++) cnt = (cnt + 1) / 2;
    return cnt;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level: adds operand pairs (0,1), (2,3), ... and
// zero-extends an odd leftover. The optional carry-in joins pair 0.
module adder_tree_level #(
  parameter int unsigned IN_CNT  = 8,
  parameter int unsigned IN_W    = 7,
  parameter int unsigned OUT_W   = 8,
  parameter bit          HAS_CI  = 1'b0,
  localparam int unsigned OUT_CNT = (IN_CNT + 1) / 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [IN_CNT*IN_W-1:0]   in_data,
  input  logic                     ci,
  output logic                     out_valid,
  output logic [OUT_CNT*OUT_W-1:0] out_data
);

  logic [OUT_CNT*OUT_W-1:0] sum_c;

  for (genvar j = 0; j < OUT_CNT; j++) begin : g_pair
    logic [OUT_W-1:0] cin_c;
    assign cin_c = (HAS_CI && (j == 0)) ? OUT_W'(ci) : '0;
    if (2 * j + 1 < IN_CNT) begin : g_add
      assign sum_c[j*OUT_W +: OUT_W] = OUT_W'(in_data[2*j*IN_W +: IN_W])
                                     + OUT_W'(in_data[(2*j+1)*IN_W +: IN_W])
                                     + cin_c;
    end else begin : g_pass
      assign sum_c[j*OUT_W +: OUT_W] = OUT_W'(in_data[2*j*IN_W +: IN_W]) + cin_c;
    end
  end

  // Flush wins over the enable for the valid bit; data simply follows the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (flush)   out_valid <= 1'b0;
      else if (en) out_valid <= in_valid;
      if (en)      out_data  <= sum_c;
    end
  end

endmodule

// File: rtl/multi_operand_adder_pipe.sv
// Pipelined NUM_OPS-operand unsigned adder with carry-in, built as a registered
// binary reduction tree with valid/ready handshakes; the whole pipe advances together.
module multi_operand_adder_pipe
  import adder_pkg::level_count, adder_pkg::sum_width, adder_pkg::level_width, adder_pkg::level_ops;
#(
  parameter int unsigned  WIDTH   = 7,
  parameter int unsigned  NUM_OPS = 8,
  localparam int unsigned LEVELS  = level_count(NUM_OPS),
  localparam int unsigned SUM_W   = sum_width(WIDTH, NUM_OPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] ops,
  input  logic                     ci,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         sum_full,
  output logic [WIDTH-1:0]         s,
  output logic                     ovf
);

  logic adv;

  // Stages hold as a block whenever a finished result is waiting downstream.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned IN_CNT  = level_ops(NUM_OPS, l);
    localparam int unsigned OUT_CNT = level_ops(NUM_OPS, l + 1);
    localparam int unsigned IN_W    = level_width(WIDTH, NUM_OPS, l);
    localparam int unsigned OUT_W   = level_width(WIDTH, NUM_OPS, l + 1);

    logic [IN_CNT*IN_W-1:0]   d_in;
    logic                     v_in;
    logic [OUT_CNT*OUT_W-1:0] d_out;
    logic                     v_out;

    if (l == 0) begin : g_src
      assign d_in = ops;
      assign v_in = in_valid;
    end else begin : g_src
      assign d_in = g_lvl[l-1].d_out;
      assign v_in = g_lvl[l-1].v_out;
    end

    adder_tree_level #(
      .IN_CNT (IN_CNT),
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .HAS_CI (l == 0)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .en        (adv),
      .in_valid  (v_in),
      .in_data   (d_in),
      .ci        (ci),
      .out_valid (v_out),
      .out_data  (d_out)
    );
  end

  // The last level's registers are the output registers.
  assign sum_full  = g_lvl[LEVELS-1].d_out;
  assign out_valid = g_lvl[LEVELS-1].v_out;
  assign s         = sum_full[WIDTH-1:0];
  assign ovf       = |sum_full[SUM_W-1:WIDTH];

endmodule
